rr_bus_arbiter: RTL and testbench
=================================

Name: rr_bus_arbiter

Overview:
- Shares one DW-bit output channel between 4 requesters using round-robin arbitration with a bounded grant tenure.
- Wraps the library's select primitives under sequential control:
  - priority-encode the rotated requests;
  - decode the winner to a one-hot grant;
  - mux the winner's data onto DOUT.
- Sits between 4 producer blocks and a single shared consumer (bus, display or UART path).

Parameters:
- DW, 8, data width per requester.
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant; legal range 1..255.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- REQ  input  4  per-requester request, level-sensitive.
- DIN  input  4*DW  requester data; requester i drives DIN[i*DW +: DW].
- GNT  output  4  one-hot grant, registered.
- GNT_ID  output  2  binary index of the granted requester, registered.
- GNT_VALID  output  1  a grant is active, registered.
- DOUT  output  DW  data of the granted requester; combinational mux from registered GNT_ID.
- DOUT_VALID  output  1  GNT_VALID & REQ[GNT_ID], combinational.

Behaviour:
- Reset (RST_N low, asynchronous):
  - GNT=0, GNT_ID=0, GNT_VALID=0, hold counter=0.
  - Round-robin pointer LAST=3, so requester 0 has top priority after reset.
  - State = IDLE.
  - DOUT=0 and DOUT_VALID=0 while GNT_VALID=0.
- States: IDLE, GRANT.
- Winner selection (pick):
  - Search order is LAST+1, LAST+2, LAST+3, LAST (mod 4); first set REQ bit wins.
  - Result: one-hot W and binary WID.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise, on the next edge: GNT=W, GNT_ID=WID, GNT_VALID=1, LAST=WID, counter=1, go to GRANT.
  - Latency from REQ rise to GNT is 1 cycle.
- GRANT: the current grant ends when either condition holds:
  - REQ[GNT_ID]==0 (requester released), or
  - counter==MAX_HOLD (tenure expired).
- GRANT, grant not ending: counter increments; GNT is unchanged.
- GRANT, grant ending:
  - Re-evaluate pick with LAST = current GNT_ID.
  - Any REQ set: switch to the new winner on the same edge (back-to-back, no idle cycle) and set counter=1.
  - If the only active request is the current holder (tenure expired, still requesting), it is re-granted with counter=1. No bubble.
  - REQ==0: GNT=0, GNT_VALID=0, go to IDLE.
- Counter width: clog2(MAX_HOLD+1). It never exceeds MAX_HOLD.
- MAX_HOLD=1: the grant rotates every cycle among active requesters.
- A request appearing mid-tenure is not served until the current tenure ends.
- A released REQ is sampled at the edge. During the release cycle DOUT_VALID=0 (combinational), and GNT drops or moves on the following edge.
- DOUT = DIN slice selected by GNT_ID when GNT_VALID=1, else 0.
- Simultaneous requests: strictly round-robin; no requester is granted twice while another active requester waits across a rotation.
- Reset asserted mid-grant: all outputs clear immediately (asynchronously). After release, arbitration restarts with requester 0 as top priority.
- GNT is always one-hot or zero. GNT and GNT_ID are always consistent.

Decomposition:
- Shared package (msi_pkg):
  - N_REQ=4, IDW=2.
  - State encoding: IDLE=1'b0, GRANT=1'b1.
- One sub-module, rr_pick:
  - Purely combinational.
  - Inputs: REQ[3:0] and LAST[1:0].
  - Rotates REQ by LAST+1, priority-encodes, rotates back.
  - Outputs: W[3:0] (one-hot), WID[1:0], ANY.
  - rr_pick is unit-tested separately.
- Top level holds the FSM, counter, LAST register and output mux.

Test Plan:
- Reset then REQ=4'b0100, DIN[2]=8'hA5 -> next cycle GNT=4'b0100, GNT_ID=2, DOUT=8'hA5, DOUT_VALID=1. Drop REQ -> on the following edge GNT=0 and state returns to IDLE.
- REQ=4'b1111 held, MAX_HOLD=8 -> grants requester 0 for 8 cycles, then 1, 2, 3, 0, each for exactly 8 cycles, with no gap cycles.
- Sole requester 1 held continuously with MAX_HOLD=3 -> GNT=4'b0010 stays asserted with no bubble. Counter sequence 1,2,3,1,2,3.
- Requester 3 granted; it drops REQ at cycle 2 while REQ[0] and REQ[1] are set -> next edge GNT=4'b0001 (round-robin from LAST=3), no idle cycle.
- RST_N pulsed low mid-grant of requester 2 -> GNT, GNT_VALID and DOUT_VALID clear without a clock edge. After release with REQ=4'b0101, requester 0 is granted first.
- MAX_HOLD=1, REQ=4'b1010 -> GNT alternates 4'b0010, 4'b1000 every cycle. DOUT tracks DIN[1] and DIN[3] accordingly.

Source files
------------

// File: rtl/msi_pkg.sv
// rtl/msi_pkg.sv - shared constants and state encoding for the round-robin bus arbiter
//   N_REQ   : number of requesters sharing the channel
//   IDW     : width of a binary requester index
//   state_t : arbiter FSM state (IDLE / GRANT)
package msi_pkg;

   localparam int N_REQ = 4;
   localparam int IDW   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection
//   req  in  : per-requester request bits
//   last in  : index of the most recently granted requester
//   w    out : one-hot winner (zero when no request)
//   wid  out : binary winner index (zero when no request)
//   any  out : at least one request is set
module rr_pick
   import msi_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   last,
   output logic [N_REQ-1:0] w,
   output logic [IDW-1:0]   wid,
   output logic             any
);

   logic             found;
   logic [IDW-1:0]   idx;

   // Walk the requesters starting just after the last winner; wrapping on
   // the 2-bit index is the rotate / encode / rotate-back in one pass.
   always_comb begin
      found = 1'b0;
      wid   = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = last + IDW'(k + 1);
         if (!found && req[idx]) begin
            found = 1'b1;
            wid   = idx;
         end
      end
      any = found;
      w   = found ? (N_REQ'(1) << wid) : '0;
   end

endmodule

// File: rtl/rr_bus_arbiter.sv
// rtl/rr_bus_arbiter.sv - 4-way round-robin arbiter with bounded grant tenure and data mux
//   clk        in  : rising-edge clock
//   rst_n      in  : asynchronous active-low reset
//   req        in  : per-requester level request
//   din        in  : requester data, requester i on din[i*DW +: DW]
//   gnt        out : registered one-hot grant
//   gnt_id     out : registered binary index of the grant holder
//   gnt_valid  out : registered, a grant is active
//   dout       out : holder's data, zero when no grant
//   dout_valid out : grant active and holder still requesting
module rr_bus_arbiter
   import msi_pkg::*;
#(
   parameter int DW       = 8,
   parameter int MAX_HOLD = 8
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] din,
   output logic [N_REQ-1:0]    gnt,
   output logic [IDW-1:0]      gnt_id,
   output logic                gnt_valid,
   output logic [DW-1:0]       dout,
   output logic                dout_valid
);

   localparam int CW = $clog2(MAX_HOLD + 1);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [IDW-1:0]   last, last_nxt;
   logic [N_REQ-1:0] gnt_nxt;
   logic [IDW-1:0]   gnt_id_nxt;
   logic             gnt_valid_nxt;

   logic [N_REQ-1:0] pick_w;
   logic [IDW-1:0]   pick_wid;
   logic             pick_any;
   logic             tenure_end;

   // While a grant is held, last equals gnt_id, so the same pointer serves
   // both the idle pick and the end-of-tenure re-pick.
   rr_pick u_pick (
      .req  (req),
      .last (last),
      .w    (pick_w),
      .wid  (pick_wid),
      .any  (pick_any)
   );

   assign tenure_end = !req[gnt_id] || (cnt == CW'(MAX_HOLD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         last      <= IDW'(N_REQ - 1);
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         last      <= last_nxt;
         gnt       <= gnt_nxt;
         gnt_id    <= gnt_id_nxt;
         gnt_valid <= gnt_valid_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      last_nxt      = last;
      gnt_nxt       = gnt;
      gnt_id_nxt    = gnt_id;
      gnt_valid_nxt = gnt_valid;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_nxt     = GRANT;
               cnt_nxt       = CW'(1);
               last_nxt      = pick_wid;
               gnt_nxt       = pick_w;
               gnt_id_nxt    = pick_wid;
               gnt_valid_nxt = 1'b1;
            end
         end
         GRANT: begin
            if (!tenure_end) begin
               cnt_nxt = cnt + CW'(1);
            end else if (pick_any) begin
               // Hand over (or re-grant the sole requester) with no bubble.
               cnt_nxt       = CW'(1);
               last_nxt      = pick_wid;
               gnt_nxt       = pick_w;
               gnt_id_nxt    = pick_wid;
               gnt_valid_nxt = 1'b1;
            end else begin
               state_nxt     = IDLE;
               cnt_nxt       = '0;
               gnt_nxt       = '0;
               gnt_valid_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      dout       = '0;
      dout_valid = 1'b0;
      if (gnt_valid) begin
         dout       = din[int'(gnt_id) * DW +: DW];
         dout_valid = req[gnt_id];
      end
   end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb/tb_rr_bus_arbiter.sv - directed self-checking bench for rr_bus_arbiter
module tb_rr_bus_arbiter;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   din;
   logic [3:0]    req8, req3, req1;

   logic [3:0]    g8, g3, g1;
   logic [1:0]    id8, id3, id1;
   logic          v8, v3, v1;
   logic [DW-1:0] d8, d3, d1;
   logic          dv8, dv3, dv1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rr_bus_arbiter #(.DW(DW), .MAX_HOLD(8)) u_arb8 (
      .clk(clk), .rst_n(rst_n), .req(req8), .din(din),
      .gnt(g8), .gnt_id(id8), .gnt_valid(v8), .dout(d8), .dout_valid(dv8));

   rr_bus_arbiter #(.DW(DW), .MAX_HOLD(3)) u_arb3 (
      .clk(clk), .rst_n(rst_n), .req(req3), .din(din),
      .gnt(g3), .gnt_id(id3), .gnt_valid(v3), .dout(d3), .dout_valid(dv3));

   rr_bus_arbiter #(.DW(DW), .MAX_HOLD(1)) u_arb1 (
      .clk(clk), .rst_n(rst_n), .req(req1), .din(din),
      .gnt(g1), .gnt_id(id1), .gnt_valid(v1), .dout(d1), .dout_valid(dv1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      req8 = 4'b0000;
      req3 = 4'b0000;
      req1 = 4'b0000;
      din  = {8'h44, 8'hA5, 8'h22, 8'h11};

      // reset state
      #2;
      chk("rst_gnt",        32'(g8),  32'h0);
      chk("rst_gnt_id",     32'(id8), 32'h0);
      chk("rst_gnt_valid",  32'(v8),  32'h0);
      chk("rst_dout",       32'(d8),  32'h0);
      chk("rst_dout_valid", 32'(dv8), 32'h0);
      rst_n = 1'b1;

      // single requester 2, then release
      step();
      req8 = 4'b0100;
      step();
      chk("r2_gnt",        32'(g8),  32'h4);
      chk("r2_gnt_id",     32'(id8), 32'h2);
      chk("r2_dout",       32'(d8),  32'hA5);
      chk("r2_dout_valid", 32'(dv8), 32'h1);
      req8 = 4'b0000;
      #1;
      chk("r2_rel_dout_valid", 32'(dv8), 32'h0);
      step();
      chk("r2_idle_gnt",   32'(g8), 32'h0);
      chk("r2_idle_valid", 32'(v8), 32'h0);

      // all four requesting, tenure 8, rotation 0,1,2,3,0 with no gaps
      do_reset();
      req8 = 4'b1111;
      for (int c = 0; c < 40; c++) begin
         step();
         chk($sformatf("rot8_gnt_c%0d", c), 32'(g8), 32'(4'b0001 << ((c / 8) % 4)));
         chk($sformatf("rot8_valid_c%0d", c), 32'(v8), 32'h1);
      end
      req8 = 4'b0000;
      step();
      step();
      chk("rot8_idle", 32'(v8), 32'h0);

      // requester 3 drops mid tenure while 0 and 1 wait
      do_reset();
      req8 = 4'b1000;
      step();
      chk("r3_gnt", 32'(g8), 32'h8);
      req8 = 4'b1011;
      step();
      chk("r3_hold_gnt", 32'(g8), 32'h8);
      chk("r3_dout", 32'(d8), 32'h44);
      req8 = 4'b0011;
      #1;
      chk("r3_rel_dout_valid", 32'(dv8), 32'h0);
      step();
      chk("r3_next_gnt",    32'(g8),  32'h1);
      chk("r3_next_gnt_id", 32'(id8), 32'h0);
      chk("r3_next_valid",  32'(v8),  32'h1);
      req8 = 4'b0000;
      step();
      step();

      // asynchronous reset mid grant of requester 2
      do_reset();
      req8 = 4'b0100;
      step();
      chk("ar_gnt", 32'(g8), 32'h4);
      rst_n = 1'b0;
      #1;
      chk("ar_gnt_clr",        32'(g8),  32'h0);
      chk("ar_valid_clr",      32'(v8),  32'h0);
      chk("ar_dout_valid_clr", 32'(dv8), 32'h0);
      req8 = 4'b0101;
      #1;
      rst_n = 1'b1;
      step();
      chk("ar_restart_gnt",    32'(g8),  32'h1);
      chk("ar_restart_gnt_id", 32'(id8), 32'h0);
      req8 = 4'b0000;

      // sole requester 1 with tenure 3: continuous re-grant, no bubble
      do_reset();
      req3 = 4'b0010;
      for (int c = 0; c < 9; c++) begin
         step();
         chk($sformatf("solo3_gnt_c%0d", c), 32'(g3), 32'h2);
         chk($sformatf("solo3_dv_c%0d", c), 32'(dv3), 32'h1);
      end
      req3 = 4'b0000;

      // tenure 1: alternate between requesters 1 and 3 every cycle
      do_reset();
      req1 = 4'b1010;
      for (int c = 0; c < 6; c++) begin
         step();
         chk($sformatf("alt1_gnt_c%0d", c), 32'(g1), (c % 2 == 0) ? 32'h2 : 32'h8);
         chk($sformatf("alt1_dout_c%0d", c), 32'(d1), (c % 2 == 0) ? 32'h22 : 32'h44);
      end
      req1 = 4'b0000;
      step();
      step();
      chk("alt1_idle", 32'(v1), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
